// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges load and ALU results into the single register file write port
// Loads win the port; ALU results wait in a small FIFO, with a starvation counter that forces an ALU slot.
module regfile_wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [31:0]                   pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [STV_W-1:0]  LIMIT_C = STV_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] XZR     = '1;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  slot_off;
  logic [STV_W-1:0]  starve_cnt;
  logic              fifo_empty;
  logic              force_alu;
  logic              alu_push;
  logic              mem_xfer;
  logic              fifo_pop;

  assign fifo_empty = (fifo_count == '0);
  assign force_alu  = (starve_cnt == LIMIT_C) && !fifo_empty;
  assign alu_ready  = (fifo_count < DEPTH_C);
  assign mem_ready  = !force_alu;
  // Writes to the zero register are accepted but simply dropped.
  assign alu_push   = alu_valid && alu_ready && (alu_addr != XZR);
  assign mem_xfer   = mem_valid && mem_ready;
  assign fifo_pop   = !mem_xfer && !fifo_empty;

  always_ff @(posedge clk) begin
    if (alu_push) begin
      q_addr[wr_ptr] <= alu_addr;
      q_data[wr_ptr] <= alu_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      starve_cnt <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      if (alu_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PTR_W'(1);

      if (alu_push && !fifo_pop)      fifo_count <= fifo_count + CNT_W'(1);
      else if (!alu_push && fifo_pop) fifo_count <= fifo_count - CNT_W'(1);

      if (fifo_pop || fifo_empty)     starve_cnt <= '0;
      else if (mem_xfer && starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + STV_W'(1);

      if (mem_xfer) begin
        wr_en   <= (mem_addr != XZR);
        wr_addr <= mem_addr;
        wr_data <= mem_data;
      end else if (fifo_pop) begin
        wr_en   <= 1'b1;
        wr_addr <= q_addr[rd_ptr];
        wr_data <= q_data[rd_ptr];
      end else begin
        wr_en   <= 1'b0;
      end
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending_mask = '0;
    slot_off     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if ({1'b0, slot_off} < fifo_count) pending_mask[q_addr[i]] = 1'b1;
    end
    pending_mask[31] = 1'b0;
  end

endmodule
